// File: rtl/tag_free_list_pkg.sv
// -----------------------------------------------------------------------------
// tag_free_list_pkg
// Shared definitions for the physical-tag free list, the rename table and the
// ROB. Everything that must agree on tag and pointer width lives here.
//   NUM_TAGS_DEF / NUM_ARCH_DEF : default physical / architectural counts
//   TAG_W, Tag_t                : physical tag width and type
//   PTR_W, Ptr_t                : free-list pointer (index plus wrap bit)
// -----------------------------------------------------------------------------
package tag_free_list_pkg;

   localparam int NUM_TAGS_DEF = 64;
   localparam int NUM_ARCH_DEF = 32;
   localparam int DEPTH_DEF    = NUM_TAGS_DEF - NUM_ARCH_DEF;

   localparam int TAG_W = $clog2(NUM_TAGS_DEF);
   localparam int PTR_W = $clog2(DEPTH_DEF) + 1;

   typedef logic [TAG_W-1:0] Tag_t;
   typedef logic [PTR_W-1:0] Ptr_t;

   // Occupancy between two wrap-bit pointers; modulo arithmetic does the work.
   function automatic Ptr_t ptr_dist(input Ptr_t head, input Ptr_t tail);
      return head - tail;
   endfunction

endpackage

// File: rtl/lane_prefix_count.sv
// -----------------------------------------------------------------------------
// lane_prefix_count
// Per-lane exclusive prefix count of a request mask, used to compact valid
// lanes onto consecutive free-list entries.
//   mask_i   [WIDTH]          lane request bits
//   prefix_o [WIDTH] x CNT_W  number of set bits strictly below lane i
//   total_o  CNT_W            popcount of mask_i
// -----------------------------------------------------------------------------
module lane_prefix_count #(
   parameter int WIDTH = 2,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0]            mask_i,
   output logic [WIDTH-1:0][CNT_W-1:0] prefix_o,
   output logic [CNT_W-1:0]            total_o
);

   logic [CNT_W-1:0] acc_s;

   // Ripple the running count through the lanes in lane order.
   always_comb begin
      acc_s    = '0;
      prefix_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         prefix_o[i] = acc_s;
         acc_s       = acc_s + CNT_W'(mask_i[i]);
      end
      total_o = acc_s;
   end

endmodule

// File: rtl/tag_free_list_chk.sv
// -----------------------------------------------------------------------------
// tag_free_list_chk
// Pointer invariants of the free list, evaluated at every rising edge while
// out of reset.
//   clk, rst           clock, active-low reset
//   spec_rd_i          speculative read pointer
//   com_rd_i           committed read pointer
//   wr_i               write pointer
//   com_n_i            number of entries being committed this cycle
// -----------------------------------------------------------------------------
module tag_free_list_chk #(
   parameter int PTR_BITS = 6,
   parameter int DEPTH    = 32,
   parameter int CNT_W    = 2
) (
   input logic                clk,
   input logic                rst,
   input logic [PTR_BITS-1:0] spec_rd_i,
   input logic [PTR_BITS-1:0] com_rd_i,
   input logic [PTR_BITS-1:0] wr_i,
   input logic [CNT_W-1:0]    com_n_i
);

   logic [PTR_BITS-1:0] in_flight_s;
   logic [PTR_BITS-1:0] owned_s;

   assign in_flight_s = spec_rd_i - com_rd_i;
   assign owned_s     = wr_i - com_rd_i;

   // Committed pointer trails speculative one; commits only retire allocated entries.
   always @(posedge clk) begin
      if (rst) begin
         assert (in_flight_s <= PTR_BITS'(DEPTH))
            else $error("tag_free_list: committed pointer overtook speculative pointer");
         assert (owned_s <= PTR_BITS'(DEPTH))
            else $error("tag_free_list: write pointer ahead of committed pointer by more than DEPTH");
         assert (PTR_BITS'(com_n_i) <= in_flight_s)
            else $error("tag_free_list: commit retires entries that were never allocated");
      end
   end

endmodule

// File: rtl/tag_free_list.sv
// -----------------------------------------------------------------------------
// tag_free_list
// Circular free-list FIFO of physical tags for the rename stage. Allocation
// reads from the speculative read pointer; commit advances the committed read
// pointer and appends the freed previous mappings at the write pointer. A
// flush rewinds the speculative pointer to the committed one in one cycle.
//   clk             clock, rising edge
//   rst             asynchronous active-low reset
//   IN_allocValid   per-lane allocation request
//   OUT_allocReady  at least WIDTH_ALLOC free entries (all-or-nothing grant)
//   OUT_allocTag    tag granted to each lane, valid lanes compacted in order
//   IN_comValid     per-lane commit
//   IN_comHasDst    committed uop owned a destination tag
//   IN_comOldTag    previous mapping to return to the free list
//   IN_flush        discard all uncommitted allocations
//   OUT_freeCount   entries available for speculative allocation
// -----------------------------------------------------------------------------
module tag_free_list
   import tag_free_list_pkg::*;
#(
   parameter int NUM_TAGS    = NUM_TAGS_DEF,
   parameter int NUM_ARCH    = NUM_ARCH_DEF,
   parameter int WIDTH_ALLOC = 2,
   parameter int WIDTH_COM   = 2
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [WIDTH_ALLOC-1:0]                       IN_allocValid,
   output logic                                         OUT_allocReady,
   output logic [WIDTH_ALLOC-1:0][$clog2(NUM_TAGS)-1:0] OUT_allocTag,
   input  logic [WIDTH_COM-1:0]                         IN_comValid,
   input  logic [WIDTH_COM-1:0]                         IN_comHasDst,
   input  logic [WIDTH_COM-1:0][$clog2(NUM_TAGS)-1:0]   IN_comOldTag,
   input  logic                                         IN_flush,
   output logic [$clog2(NUM_TAGS-NUM_ARCH):0]           OUT_freeCount
);

   localparam int DEPTH    = NUM_TAGS - NUM_ARCH;
   localparam int TAG_BITS = $clog2(NUM_TAGS);
   localparam int IDX_BITS = $clog2(DEPTH);
   localparam int PTR_BITS = IDX_BITS + 1;
   localparam int ACNT_W   = $clog2(WIDTH_ALLOC + 1);
   localparam int CCNT_W   = $clog2(WIDTH_COM + 1);

   logic [PTR_BITS-1:0]                  spec_rd_q, spec_rd_d;
   logic [PTR_BITS-1:0]                  com_rd_q,  com_rd_d;
   logic [PTR_BITS-1:0]                  wr_q,      wr_d;
   logic [DEPTH-1:0][TAG_BITS-1:0]       entry_q,   entry_d;

   logic [WIDTH_ALLOC-1:0][ACNT_W-1:0]   alloc_pre_s;
   logic [ACNT_W-1:0]                    alloc_n_s;
   logic [WIDTH_COM-1:0]                 com_mask_s;
   logic [WIDTH_COM-1:0][CCNT_W-1:0]     com_pre_s;
   logic [CCNT_W-1:0]                    com_n_s;
   logic [WIDTH_ALLOC-1:0][IDX_BITS-1:0] rd_idx_s;
   logic [WIDTH_COM-1:0][IDX_BITS-1:0]   wr_idx_s;
   logic [PTR_BITS-1:0]                  free_cnt_s;
   logic                                 ready_s;

   assign com_mask_s = IN_comValid & IN_comHasDst;

   lane_prefix_count #(
      .WIDTH (WIDTH_ALLOC),
      .CNT_W (ACNT_W)
   ) u_alloc_prefix (
      .mask_i   (IN_allocValid),
      .prefix_o (alloc_pre_s),
      .total_o  (alloc_n_s)
   );

   lane_prefix_count #(
      .WIDTH (WIDTH_COM),
      .CNT_W (CCNT_W)
   ) u_com_prefix (
      .mask_i   (com_mask_s),
      .prefix_o (com_pre_s),
      .total_o  (com_n_s)
   );

   // Free entries and readiness come straight from registered pointers.
   always_comb begin
      free_cnt_s = ptr_dist(wr_q, spec_rd_q);
      ready_s    = (free_cnt_s >= PTR_BITS'(WIDTH_ALLOC));
   end

   // Lane i reads entry[specRd + prefix]; index arithmetic wraps on the low bits.
   always_comb begin
      rd_idx_s     = '0;
      OUT_allocTag = '0;
      for (int i = 0; i < WIDTH_ALLOC; i++) begin
         rd_idx_s[i]     = spec_rd_q[IDX_BITS-1:0] + IDX_BITS'(alloc_pre_s[i]);
         OUT_allocTag[i] = entry_q[rd_idx_s[i]];
      end
   end

   // Released tags land at wr + prefix; no bypass to this cycle's reads.
   always_comb begin
      wr_idx_s = '0;
      entry_d  = entry_q;
      for (int i = 0; i < WIDTH_COM; i++) begin
         wr_idx_s[i] = wr_q[IDX_BITS-1:0] + IDX_BITS'(com_pre_s[i]);
         if (com_mask_s[i]) begin
            entry_d[wr_idx_s[i]] = IN_comOldTag[i];
         end else begin
            entry_d[wr_idx_s[i]] = entry_d[wr_idx_s[i]];
         end
      end
   end

   // Pointer next state; a flush lands on the post-commit committed pointer.
   always_comb begin
      com_rd_d  = com_rd_q + PTR_BITS'(com_n_s);
      wr_d      = wr_q + PTR_BITS'(com_n_s);
      spec_rd_d = spec_rd_q;
      if (IN_flush) begin
         spec_rd_d = com_rd_d;
      end else if (ready_s) begin
         spec_rd_d = spec_rd_q + PTR_BITS'(alloc_n_s);
      end else begin
         spec_rd_d = spec_rd_q;
      end
   end

   // State registers; reset loads the identity free list NUM_ARCH..NUM_TAGS-1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         spec_rd_q <= '0;
         com_rd_q  <= '0;
         wr_q      <= PTR_BITS'(DEPTH);
         for (int k = 0; k < DEPTH; k++) begin
            entry_q[k] <= TAG_BITS'(NUM_ARCH + k);
         end
      end else begin
         spec_rd_q <= spec_rd_d;
         com_rd_q  <= com_rd_d;
         wr_q      <= wr_d;
         entry_q   <= entry_d;
      end
   end

   assign OUT_freeCount  = free_cnt_s;
   assign OUT_allocReady = ready_s;

   tag_free_list_chk #(
      .PTR_BITS (PTR_BITS),
      .DEPTH    (DEPTH),
      .CNT_W    (CCNT_W)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .spec_rd_i (spec_rd_q),
      .com_rd_i  (com_rd_q),
      .wr_i      (wr_q),
      .com_n_i   (com_n_s)
   );

endmodule

// File: doc/tag_free_list.md
# tag_free_list

- Parametrised physical-tag allocator for the rename stage. Replaces the scan-for-unused-tag search with a circular free-list FIFO.
- Three pointers:
  - speculative read pointer, for allocation;
  - committed read pointer, advanced at commit;
  - write pointer, for tags released at commit.
- A flush restores the speculative pointer to the committed one in one cycle.
- Sits between decode and the rename table; the ROB commit port drives its release side.

## Interface
- NUM_TAGS, 64: physical tags; NUM_TAGS-NUM_ARCH must be a power of two.
- NUM_ARCH, 32: architectural registers; tags 0..NUM_ARCH-1 are committed mappings at reset.
- WIDTH_ALLOC, 2: allocation lanes per cycle.
- WIDTH_COM, 2: commit lanes per cycle.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- IN_allocValid  in  [WIDTH_ALLOC]  lane i requests a tag (uop valid and rd != 0).
- OUT_allocReady  out  1  free entries >= WIDTH_ALLOC; all-or-nothing.
- OUT_allocTag  out  [WIDTH_ALLOC] x TAG_W  tag granted to lane i; valid when OUT_allocReady.
- IN_comValid  in  [WIDTH_COM]  lane commits.
- IN_comHasDst  in  [WIDTH_COM]  committed uop had allocated a tag.
- IN_comOldTag  in  [WIDTH_COM] x TAG_W  previous committed mapping, to be freed.
- IN_flush  in  1  discard all uncommitted allocations.
- OUT_freeCount  out  PTR_W  entries available for speculative allocation.

## Operation
- DEPTH = NUM_TAGS-NUM_ARCH.
- PTR_W = log2(DEPTH)+1; the MSB is the wrap bit.
- Storage is DEPTH entries of TAG_W = log2(NUM_TAGS).
- Reset (rst low, asynchronous):
  - entry k = NUM_ARCH+k;
  - specRd = comRd = 0; wr = DEPTH;
  - OUT_freeCount = DEPTH; OUT_allocReady = 1 (requires DEPTH >= WIDTH_ALLOC).
- Allocation:
  - Valid lanes are compacted in lane order. Lane i receives entry[specRd + (number of valid lanes below i)].
  - OUT_allocTag for an invalid lane is don't-care.
  - On the edge with OUT_allocReady && !IN_flush, specRd advances by popcount(IN_allocValid).
- Commit:
  - Lanes with valid && hasDst (n of them) advance comRd by n.
  - The same lanes write IN_comOldTag to entry[wr + prefix], in lane order; wr advances by n.
  - Commit is never stalled by this block.
- Flush: specRd <= comRd + n, where n is the same-cycle commit count. Allocation in that cycle is ignored.
- OUT_freeCount = wr - specRd (modulo 2^PTR_W). OUT_allocReady = OUT_freeCount >= WIDTH_ALLOC.
- Invariants, checked by assertions:
  - comRd never overtakes specRd;
  - wr - comRd <= DEPTH;
  - comRd advances only over previously allocated entries.

## Timing
- Allocation is combinational from registered state: tags and ready are valid in the request cycle and consumed at the edge.
- Released tags become allocatable the cycle after the commit edge; there is no same-cycle bypass.
- Flush takes effect at the edge. The next cycle's OUT_freeCount reflects the full recovery.
- Commit and alloc in the same cycle touch disjoint pointers. An entry freed in cycle t can be granted at t+1 at the earliest.
- Wrap-around: all pointer arithmetic is modulo 2^PTR_W; storage is indexed by the low log2(DEPTH) bits.
- Reset asserted mid-operation discards all state, including in-flight commits.

## Structure
- Shared package holds:
  - TAG_W / SqN-style typedef Tag_t;
  - the pointer typedef;
  - the NUM_TAGS and NUM_ARCH defaults, so the rename table and ROB agree.
- Sub-module lane_prefix_count: WIDTH-bit mask in, per-lane exclusive prefix counts and total popcount out. Instantiated once for alloc and once for commit.

## Test plan
- Reset, then alloc lanes {1,1} each cycle for 16 cycles:
  - grants 32,33 ... 62,63;
  - OUT_allocReady drops at freeCount=0.
- Alloc mask {0,1}, i.e. lane 1 only: lane 1 gets tag 32 and specRd advances by 1. Then mask {1,1} gives 33,34.
- Allocate 6, commit 2 with hasDst (old tags 5,7), then flush in the next cycle:
  - next grants are 34,35 (not 38);
  - tags 5,7 become allocatable after the entries ahead of them.
- Flush coincident with 1 commit and an alloc request: specRd = comRd+1, and no tags are consumed that cycle.
- Drain to freeCount=1 with WIDTH_ALLOC=2:
  - ready=0 even for a single-lane request;
  - a commit freeing tag 9 raises ready the next cycle.
- Pulse rst low asynchronously mid-burst: outputs immediately show freeCount=32 and ready=1, and the next grant is 32.
